// File: rtl/drbg_reseed_scheduler.sv
// Issues one generate or reseed command at a time to the hash-DRBG core and
// keeps the per-epoch generate count and the internal reseed sequence number.
module drbg_reseed_scheduler #(
  parameter int GENERATES_PER_RESEED = 480,
  parameter int DONE_TIMEOUT         = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic        line_start,
  input  logic        catch_up_mode,
  input  logic        get_next_seed,
  input  logic        block_drbg_reseed,
  input  logic        drbg_gen_done,
  input  logic        drbg_reseed_done,
  output logic        drbg_generate,
  output logic        drbg_reseed,
  output logic        key_valid,
  output logic [31:0] sequence_internal,
  output logic        V,
  output logic        line_overrun,
  output logic        timeout_fault
);

  localparam int CW = $clog2(GENERATES_PER_RESEED + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CW-1:0] GEN_LIMIT = CW'(GENERATES_PER_RESEED);
  localparam logic [TW-1:0] TMO_LAST  = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    WAIT_INIT,
    READY,
    GEN_WAIT,
    RESEED_WAIT
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   gen_count;
  logic [TW-1:0]   timer;
  logic            line_pending;

  logic reseed_due, gen_ok, issue_reseed, issue_gen, timed_out;
  logic gen_done_hit, rsd_done_hit, gen_expire, rsd_expire, pending_clear;

  // Done pulses only count while the matching command is outstanding.
  assign reseed_due    = !block_drbg_reseed && (get_next_seed || gen_count == GEN_LIMIT);
  assign gen_ok        = line_pending && (gen_count < GEN_LIMIT);
  assign issue_reseed  = (state == READY) && reseed_due;
  assign issue_gen     = (state == READY) && !reseed_due && gen_ok;
  assign timed_out     = (timer == TMO_LAST);
  assign gen_done_hit  = (state == GEN_WAIT) && drbg_gen_done;
  assign rsd_done_hit  = (state == RESEED_WAIT) && drbg_reseed_done;
  assign gen_expire    = (state == GEN_WAIT) && !drbg_gen_done && timed_out;
  assign rsd_expire    = (state == RESEED_WAIT) && !drbg_reseed_done && timed_out;
  // An expired generate drops its line so the command is not reissued.
  assign pending_clear = gen_done_hit || gen_expire;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      WAIT_INIT:   if (init_done) state_next = READY;
      READY: begin
        if (issue_reseed)   state_next = RESEED_WAIT;
        else if (issue_gen) state_next = GEN_WAIT;
      end
      GEN_WAIT:    if (drbg_gen_done || timed_out) state_next = READY;
      RESEED_WAIT: if (drbg_reseed_done || timed_out) state_next = READY;
      default:     state_next = WAIT_INIT;
    endcase
    if (!init_done) state_next = WAIT_INIT;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= WAIT_INIT;
      gen_count         <= '0;
      timer             <= '0;
      line_pending      <= 1'b0;
      drbg_generate     <= 1'b0;
      drbg_reseed       <= 1'b0;
      key_valid         <= 1'b0;
      sequence_internal <= '0;
      V                 <= 1'b0;
      line_overrun      <= 1'b0;
      timeout_fault     <= 1'b0;
    end else begin
      state         <= state_next;
      drbg_generate <= init_done && issue_gen;
      drbg_reseed   <= init_done && issue_reseed;
      key_valid     <= init_done && gen_done_hit && !catch_up_mode;

      if (!init_done) begin
        // Core is being re-instantiated; sticky fault flags survive this.
        gen_count         <= '0;
        timer             <= '0;
        line_pending      <= 1'b0;
        sequence_internal <= '0;
        V                 <= 1'b0;
      end else begin
        if (state == GEN_WAIT || state == RESEED_WAIT) timer <= timer + TW'(1);
        else                                           timer <= '0;

        if (gen_done_hit) begin
          gen_count <= gen_count + CW'(1);
          V         <= 1'b1;
        end
        if (rsd_done_hit) begin
          sequence_internal <= sequence_internal + 32'd1;
          gen_count         <= '0;
          V                 <= 1'b0;
        end
        if (gen_expire || rsd_expire) timeout_fault <= 1'b1;

        if (line_start && state != WAIT_INIT) begin
          if (line_pending && !pending_clear) line_overrun <= 1'b1;
          line_pending <= 1'b1;
        end else if (pending_clear) begin
          line_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_drbg_reseed_scheduler.sv
// Self-checking bench for drbg_reseed_scheduler: directed vector table, hand
// sequences for catch-up/hold/timeout/init-drop/wrap, and a random scoreboard run.
module tb_drbg_reseed_scheduler;

  localparam int LIMIT = 4;
  localparam int TMO   = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done, line_start, catch_up_mode, get_next_seed, block_drbg_reseed;
  logic        drbg_gen_done, drbg_reseed_done;
  logic        drbg_generate, drbg_reseed, key_valid, V, line_overrun, timeout_fault;
  logic [31:0] sequence_internal;

  int vectors = 0;
  int miscompares = 0;

  drbg_reseed_scheduler #(
    .GENERATES_PER_RESEED(LIMIT),
    .DONE_TIMEOUT        (TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .init_done        (init_done),
    .line_start       (line_start),
    .catch_up_mode    (catch_up_mode),
    .get_next_seed    (get_next_seed),
    .block_drbg_reseed(block_drbg_reseed),
    .drbg_gen_done    (drbg_gen_done),
    .drbg_reseed_done (drbg_reseed_done),
    .drbg_generate    (drbg_generate),
    .drbg_reseed      (drbg_reseed),
    .key_valid        (key_valid),
    .sequence_internal(sequence_internal),
    .V                (V),
    .line_overrun     (line_overrun),
    .timeout_fault    (timeout_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Input bits {init, ls, cu, gns, blk, gd, rd}; output bits {gen, rsd, kv, v}.
  typedef struct {
    logic [6:0]  in;
    logic [3:0]  out;
    logic [31:0] seq;
  } vec_t;

  vec_t tbl[$];

  localparam logic [6:0] IN_IDLE = 7'b1000000;
  localparam logic [6:0] IN_LS   = 7'b1100000;
  localparam logic [6:0] IN_GD   = 7'b1000010;
  localparam logic [6:0] IN_RD   = 7'b1000001;
  localparam logic [6:0] IN_LSGD = 7'b1100010;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [6:0] in, input logic [3:0] out, input logic [31:0] seq);
    vec_t r;
    r.in = in; r.out = out; r.seq = seq;
    tbl.push_back(r);
  endtask

  // Returns 1 for a generate, 2 for a reseed, 0 when the budget runs out.
  task automatic wait_cmd(input int budget, output int which);
    which = 0;
    for (int i = 0; i < budget; i++) begin
      if (drbg_generate) begin which = 1; return; end
      if (drbg_reseed)   begin which = 2; return; end
      tick();
    end
  endtask

  task automatic pulse_gd();
    drbg_gen_done = 1'b1; tick(); drbg_gen_done = 1'b0;
  endtask

  task automatic pulse_rd();
    drbg_reseed_done = 1'b1; tick(); drbg_reseed_done = 1'b0;
  endtask

  task automatic serve_line(input string name, input logic exp_kv);
    int w;
    line_start = 1'b1; tick(); line_start = 1'b0;
    wait_cmd(8, w);
    check({name, ".cmd"}, w, 1);
    pulse_gd();
    check({name, ".key_valid"}, key_valid, exp_kv);
  endtask

  task automatic quiet(input string name, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen |= drbg_generate | drbg_reseed;
    end
    check(name, seen, 1'b0);
  endtask

  // Random-phase scoreboard state.
  int          outstanding, delay, done_kind, epoch_gens;
  logic        exp_v;
  logic [31:0] exp_seq;
  logic        cu_now, gns_now, blk_now;

  initial begin
    int w;
    reset = 1'b1;
    {init_done, line_start, catch_up_mode, get_next_seed, block_drbg_reseed} = '0;
    {drbg_gen_done, drbg_reseed_done} = '0;
    tick(); tick();
    check("rst.generate", drbg_generate, 0);
    check("rst.reseed", drbg_reseed, 0);
    check("rst.key_valid", key_valid, 0);
    check("rst.seq", sequence_internal, 0);
    check("rst.V", V, 0);
    check("rst.overrun", line_overrun, 0);
    check("rst.timeout", timeout_fault, 0);
    reset = 1'b0;

    // Basic generate path, limit-driven reseed, same-cycle line/done capture.
    add(IN_IDLE, 4'b0000, 0);
    add(IN_LS,   4'b0000, 0);
    add(IN_IDLE, 4'b1000, 0);
    for (int i = 0; i < 5; i++) add(IN_IDLE, 4'b0000, 0);
    add(IN_GD,   4'b0011, 0);
    for (int k = 0; k < 3; k++) begin
      add(IN_LS,   4'b0001, 0);
      add(IN_IDLE, 4'b1001, 0);
      add(IN_GD,   4'b0011, 0);
    end
    add(IN_IDLE, 4'b0101, 0);
    add(IN_LS,   4'b0001, 0);
    add(IN_RD,   4'b0000, 1);
    add(IN_IDLE, 4'b1000, 1);
    add(IN_GD,   4'b0011, 1);
    add(IN_LS,   4'b0001, 1);
    add(IN_IDLE, 4'b1001, 1);
    add(IN_LSGD, 4'b0011, 1);
    add(IN_IDLE, 4'b1001, 1);
    add(IN_GD,   4'b0011, 1);
    add(IN_IDLE, 4'b0001, 1);

    foreach (tbl[i]) begin
      {init_done, line_start, catch_up_mode, get_next_seed, block_drbg_reseed,
       drbg_gen_done, drbg_reseed_done} = tbl[i].in;
      tick();
      check($sformatf("tbl[%0d].generate", i), drbg_generate, tbl[i].out[3]);
      check($sformatf("tbl[%0d].reseed", i), drbg_reseed, tbl[i].out[2]);
      check($sformatf("tbl[%0d].key_valid", i), key_valid, tbl[i].out[1]);
      check($sformatf("tbl[%0d].V", i), V, tbl[i].out[0]);
      check($sformatf("tbl[%0d].seq", i), sequence_internal, tbl[i].seq);
    end
    {line_start, drbg_gen_done, drbg_reseed_done} = '0;

    // Catch-up: three back-to-back reseeds ahead of a pending line.
    catch_up_mode = 1'b1; get_next_seed = 1'b1; line_start = 1'b1;
    tick(); line_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_cmd(8, w);
      check($sformatf("cu.reseed%0d", i), w, 2);
      drbg_reseed_done = 1'b1;
      if (i == 2) get_next_seed = 1'b0;
      tick(); drbg_reseed_done = 1'b0;
      check($sformatf("cu.seq%0d", i), sequence_internal, 32'(2 + i));
    end
    wait_cmd(8, w);
    check("cu.gen_after", w, 1);
    pulse_gd();
    check("cu.no_key_valid", key_valid, 0);
    check("cu.V", V, 1);
    catch_up_mode = 1'b0;

    // Hold at the limit: lines pile up as overrun, one generate after release.
    block_drbg_reseed = 1'b1;
    for (int i = 0; i < 3; i++) serve_line($sformatf("hold.line%0d", i), 1'b1);
    line_start = 1'b1; tick(); line_start = 1'b0; tick();
    check("hold.overrun_before", line_overrun, 0);
    line_start = 1'b1; tick(); line_start = 1'b0;
    check("hold.overrun", line_overrun, 1);
    quiet("hold.no_cmd", 6);
    block_drbg_reseed = 1'b0;
    wait_cmd(8, w);
    check("hold.reseed", w, 2);
    pulse_rd();
    check("hold.seq", sequence_internal, 5);
    wait_cmd(8, w);
    check("hold.gen", w, 1);
    pulse_gd();
    check("hold.key_valid", key_valid, 1);
    quiet("hold.single_gen", 6);

    // Generate timeout.
    line_start = 1'b1; tick(); line_start = 1'b0;
    wait_cmd(8, w);
    check("tmo.gen", w, 1);
    begin
      int n = 0;
      while (!timeout_fault && n < TMO + 50) begin tick(); n++; end
      check("tmo.cycles", n, TMO);
    end
    check("tmo.fault", timeout_fault, 1);
    quiet("tmo.no_retry", 5);
    serve_line("tmo.ready_again", 1'b1);

    // init_done drops mid-generate.
    line_start = 1'b1; tick(); line_start = 1'b0;
    wait_cmd(8, w);
    check("init.gen", w, 1);
    tick(); tick();
    check("init.V_before", V, 1);
    init_done = 1'b0; tick();
    check("init.V_cleared", V, 0);
    check("init.seq_cleared", sequence_internal, 0);
    drbg_gen_done = 1'b1; line_start = 1'b1; tick();
    drbg_gen_done = 1'b0; line_start = 1'b0;
    check("init.done_ignored", key_valid, 0);
    check("init.sticky_tmo", timeout_fault, 1);
    check("init.sticky_ovr", line_overrun, 1);
    init_done = 1'b1; tick();
    quiet("init.line_ignored", 4);
    for (int i = 0; i < LIMIT; i++) serve_line($sformatf("init.line%0d", i), 1'b1);
    wait_cmd(4, w);
    check("init.limit_reseed", w, 2);
    pulse_rd();
    check("init.seq", sequence_internal, 1);
    check("init.V_epoch", V, 0);

    // Random scoreboard run with the bench acting as the DRBG core.
    outstanding = 0; delay = 0; epoch_gens = 0; exp_v = 1'b0; exp_seq = 32'd1;
    for (int cyc = 0; cyc < 3000 || (outstanding != 0 && cyc < 3040); cyc++) begin
      done_kind = 0;
      drbg_gen_done = 1'b0; drbg_reseed_done = 1'b0;
      if (cyc < 3000) begin
        if ($urandom_range(0, 15) == 0) catch_up_mode = ~catch_up_mode;
        if ($urandom_range(0, 19) == 0) block_drbg_reseed = ~block_drbg_reseed;
        get_next_seed = ($urandom_range(0, 19) == 0);
        line_start    = ($urandom_range(0, 5) == 0);
      end else begin
        {get_next_seed, line_start, block_drbg_reseed} = '0;
      end
      if (outstanding != 0) begin
        if (delay == 0) begin
          done_kind = outstanding;
          if (outstanding == 1) drbg_gen_done = 1'b1;
          else                  drbg_reseed_done = 1'b1;
        end else begin
          delay--;
        end
      end
      cu_now = catch_up_mode; gns_now = get_next_seed; blk_now = block_drbg_reseed;
      tick();
      if (done_kind == 1) begin
        epoch_gens++; exp_v = 1'b1; outstanding = 0;
        check("rnd.key_valid", key_valid, !cu_now);
      end else if (done_kind == 2) begin
        exp_seq++; epoch_gens = 0; exp_v = 1'b0; outstanding = 0;
      end
      check("rnd.V", V, exp_v);
      check("rnd.seq", sequence_internal, exp_seq);
      if (drbg_generate || drbg_reseed) begin
        check("rnd.one_outstanding", outstanding, 0);
        check("rnd.single_cmd", drbg_generate & drbg_reseed, 0);
        if (drbg_generate) begin
          check("rnd.gen_under_limit", epoch_gens < LIMIT, 1);
          outstanding = 1;
        end else begin
          check("rnd.reseed_allowed", !blk_now && (gns_now || epoch_gens == LIMIT), 1);
          outstanding = 2;
        end
        delay = $urandom_range(0, 4);
      end
    end
    {drbg_gen_done, drbg_reseed_done, line_start, catch_up_mode, block_drbg_reseed} = '0;

    // Sequence number wrap.
    get_next_seed = 1'b1;
    begin
      logic wrapped = 1'b0;
      for (int i = 0; i < 20 && !wrapped; i++) begin
        wait_cmd(10, w);
        if (w == 1) begin
          pulse_gd();
        end else if (w == 2) begin
          force dut.sequence_internal = 32'hFFFF_FFFF;
          #1;
          release dut.sequence_internal;
          pulse_rd();
          check("wrap.seq", sequence_internal, 0);
          wrapped = 1'b1;
        end else begin
          break;
        end
      end
      check("wrap.reached", wrapped, 1);
    end
    get_next_seed = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
